aes_cipher: RTL and testbench

AES_CIPHER -- requirements
Module: aes_cipher

---
 rtl/aes_pkg.sv | 60 ++++++
 rtl/aes_cipher_key_expansion.sv | 85 ++++++++
 rtl/aes_cipher.sv | 127 ++++++++++++
 tb/tb_aes_cipher.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants and byte-level helpers for the cipher and its key expansion.
// S-box, Rcon, GF(2^8) arithmetic and the state encodings used by both FSMs.
package aes_pkg;

  localparam int NB        = 4;
  localparam int MAX_WORDS = 60;

  // Byte b of the S-box lives at bits [2047-8*b -: 8].
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [7:0] RCON [16] = '{
    8'h8d, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
    8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  typedef enum logic [1:0] {KS_LOAD, KS_EXPAND, KS_DONE} ksState_t;
  typedef enum logic [1:0] {C_WAIT, C_ROUND, C_DONE} cipherState_t;

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

  function automatic logic [31:0] subWord(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

endpackage

// File: rtl/aes_cipher_key_expansion.sv
// AES key expansion: loads the key words, then derives one schedule word per cycle.
// Words past the last one needed for the selected key size are never written.
module key_expansion
  import aes_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic [255:0]               key,
  input  logic [3:0]                 nk,
  output logic [32*MAX_WORDS-1:0]    key_schedule,
  output logic                       key_expansion_done
);

  ksState_t    ksState;
  logic [31:0] words [MAX_WORDS];
  logic [5:0]  wordIdx;
  logic [3:0]  modCnt;
  logic [3:0]  rconIdx;

  logic [5:0]   lastIdx;
  logic [8:0]   keyShift;
  logic [255:0] keyAligned;
  logic [31:0]  prevWord;
  logic [31:0]  backWord;
  logic [31:0]  tempWord;
  logic [31:0]  nextWord;

  always_comb begin
    lastIdx    = {nk + 4'd7, 2'b00} - 6'd1;
    // Left-justify the key so word 0 always sits at the top.
    keyShift   = {4'd8 - nk, 5'b00000};
    keyAligned = key << keyShift;
    prevWord   = words[wordIdx - 6'd1];
    backWord   = words[wordIdx - {2'b00, nk}];
    if (modCnt == 4'd0)
      tempWord = subWord({prevWord[23:0], prevWord[31:24]}) ^ {RCON[rconIdx], 24'h000000};
    else if (nk == 4'd8 && modCnt == 4'd4)
      tempWord = subWord(prevWord);
    else
      tempWord = prevWord;
    nextWord = backWord ^ tempWord;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ksState            <= KS_LOAD;
      for (int j = 0; j < MAX_WORDS; j++) words[j] <= '0;
      wordIdx            <= '0;
      modCnt             <= '0;
      rconIdx            <= '0;
      key_expansion_done <= 1'b0;
    end else begin
      case (ksState)
        KS_LOAD: begin
          for (int j = 0; j < 8; j++)
            if (j < int'(nk)) words[j] <= keyAligned[255-32*j -: 32];
          wordIdx <= {2'b00, nk};
          modCnt  <= 4'd0;
          rconIdx <= 4'd1;
          ksState <= KS_EXPAND;
        end
        KS_EXPAND: begin
          words[wordIdx] <= nextWord;
          wordIdx        <= wordIdx + 6'd1;
          if (modCnt == nk - 4'd1) begin
            modCnt  <= 4'd0;
            rconIdx <= rconIdx + 4'd1;
          end else begin
            modCnt  <= modCnt + 4'd1;
          end
          if (wordIdx == lastIdx) begin
            key_expansion_done <= 1'b1;
            ksState            <= KS_DONE;
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < MAX_WORDS; g++) begin : g_flatten
    assign key_schedule[32*MAX_WORDS-1-32*g -: 32] = words[g];
  end

endmodule

// File: rtl/aes_cipher.sv
// AES encryption core: inputs captured under reset, key expanded, then one round per cycle.
// cipher_text stays zero until the final round lands and then holds until the next reset.
module aes_cipher
  import aes_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic [7:0]     nk,
  input  logic [127:0]   plain_text,
  input  logic [255:0]   cipher_key,
  output logic [127:0]   cipher_text,
  output logic [1919:0]  key_schedule,
  output logic           key_expansion_done,
  output logic           cipher_done
);

  logic [3:0]   nkReg;
  logic [255:0] keyReg;
  logic [127:0] ptReg;

  cipherState_t cState;
  logic [127:0] aesState;
  logic [3:0]   round;
  logic [3:0]   numRounds;
  logic [10:0]  rkTop;
  logic [127:0] roundKey;
  logic [127:0] sbState;
  logic [127:0] srState;
  logic [127:0] mcState;
  logic [127:0] roundOut;

  function automatic logic [3:0] normNk(input logic [7:0] n);
    if (n == 8'd6) return 4'd6;
    if (n == 8'd8) return 4'd8;
    return 4'd4;
  endfunction

  function automatic logic [127:0] subBytes(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sbox(s[127-8*i -: 8]);
    return r;
  endfunction

  // Byte (row r, column c) sits at index 4*c+r, column-major as in the block layout.
  function automatic logic [127:0] shiftRows(input logic [127:0] s);
    logic [127:0] r;
    for (int c = 0; c < NB; c++)
      for (int w = 0; w < 4; w++)
        r[127-8*(4*c+w) -: 8] = s[127-8*(4*((c+w)%NB)+w) -: 8];
    return r;
  endfunction

  function automatic logic [127:0] mixColumns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < NB; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = xtime(a0) ^ gfMul(8'h03, a1) ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ xtime(a1) ^ gfMul(8'h03, a2) ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ gfMul(8'h03, a3);
      r[103-32*c -: 8] = gfMul(8'h03, a0) ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      nkReg  <= normNk(nk);
      keyReg <= cipher_key;
      ptReg  <= plain_text;
    end
  end

  key_expansion uKeyExpansion (
    .clk                (clk),
    .reset              (reset),
    .key                (keyReg),
    .nk                 (nkReg),
    .key_schedule       (key_schedule),
    .key_expansion_done (key_expansion_done)
  );

  always_comb begin
    numRounds = nkReg + 4'd6;
    rkTop     = 11'd1919 - {round, 7'b0000000};
    roundKey  = key_schedule[rkTop -: 128];
    sbState   = subBytes(aesState);
    srState   = shiftRows(sbState);
    mcState   = mixColumns(srState);
    roundOut  = ((round == numRounds) ? srState : mcState) ^ roundKey;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cState      <= C_WAIT;
      aesState    <= '0;
      round       <= '0;
      cipher_text <= '0;
      cipher_done <= 1'b0;
    end else begin
      case (cState)
        C_WAIT: begin
          if (key_expansion_done) begin
            aesState <= ptReg ^ key_schedule[1919 -: 128];
            round    <= 4'd1;
            cState   <= C_ROUND;
          end
        end
        C_ROUND: begin
          aesState <= roundOut;
          if (round == numRounds) begin
            cipher_text <= roundOut;
            cipher_done <= 1'b1;
            cState      <= C_DONE;
          end else begin
            round <= round + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_cipher.sv
// Scoreboard bench for aes_cipher: expected results queued at stimulus, compared at cipher_done.
module tb_aes_cipher;

  logic           clk = 1'b0;
  logic           reset;
  logic [7:0]     nk;
  logic [127:0]   plain_text;
  logic [255:0]   cipher_key;
  logic [127:0]   cipher_text;
  logic [1919:0]  key_schedule;
  logic           key_expansion_done;
  logic           cipher_done;

  always #5 clk = ~clk;

  aes_cipher dut (
    .clk                (clk),
    .reset              (reset),
    .nk                 (nk),
    .plain_text         (plain_text),
    .cipher_key         (cipher_key),
    .cipher_text        (cipher_text),
    .key_schedule       (key_schedule),
    .key_expansion_done (key_expansion_done),
    .cipher_done        (cipher_done)
  );

  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY128 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [191:0] KEY192 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

  typedef struct {
    logic [127:0] ct;
    int           kedCycle;
    int           latency;
  } expect_t;

  expect_t sbQueue [$];
  int checkCount = 0;
  int errorCount = 0;

  task automatic checkVal(input string tag, input logic [511:0] actual, input logic [511:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Expected timing is derived from the key size alone: key words load in cycle 1,
  // the remaining words take one cycle each, and encryption takes Nr+1 cycles.
  task automatic startRun(input logic [7:0] nkVal, input logic [255:0] keyVal,
                          input logic [127:0] ptVal, input logic [127:0] expCt);
    int nkEff;
    expect_t e;
    nkEff      = (nkVal == 8'd6 || nkVal == 8'd8) ? int'(nkVal) : 4;
    e.ct       = expCt;
    e.kedCycle = 4 * (nkEff + 7) - nkEff + 1;
    e.latency  = nkEff + 7;
    sbQueue.push_back(e);
    @(negedge clk);
    reset      = 1'b1;
    nk         = nkVal;
    cipher_key = keyVal;
    plain_text = ptVal;
    repeat (2) @(negedge clk);
    checkVal("resetOutputs", {cipher_text, key_expansion_done, cipher_done, |key_schedule}, '0);
    reset      = 1'b0;
    nk         = 8'd8;
    cipher_key = {$urandom(), $urandom(), $urandom(), $urandom(),
                  $urandom(), $urandom(), $urandom(), $urandom()};
    plain_text = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic waitResult(input string tag);
    int      cyc = 0;
    int      kedAt = -1;
    bit      seenDone = 1'b0;
    bit      ctLeak = 1'b0;
    expect_t e;
    while (cyc < 200 && !seenDone) begin
      @(negedge clk);
      cyc++;
      if (key_expansion_done && kedAt < 0) kedAt = cyc;
      if (cipher_done) seenDone = 1'b1;
      else if (cipher_text !== '0) ctLeak = 1'b1;
    end
    e = sbQueue.pop_front();
    checkVal({tag, "_done"}, 512'(seenDone), 512'd1);
    checkVal({tag, "_kedCycle"}, 512'(kedAt), 512'(e.kedCycle));
    checkVal({tag, "_latency"}, 512'(cyc - kedAt), 512'(e.latency));
    checkVal({tag, "_ct"}, 512'(cipher_text), 512'(e.ct));
    checkVal({tag, "_ctZeroBeforeDone"}, 512'(ctLeak), '0);
    repeat (4) @(negedge clk);
    checkVal({tag, "_hold"}, {cipher_text, key_expansion_done, cipher_done}, {e.ct, 2'b11});
  endtask

  initial begin
    reset      = 1'b1;
    nk         = 8'd4;
    cipher_key = '0;
    plain_text = '0;

    startRun(8'd4, {128'hdeadbeefcafef00d0123456789abcdef, KEY128}, PT, CT128);
    waitResult("nk4");
    startRun(8'd6, {64'h0, KEY192}, PT, CT192);
    waitResult("nk6");
    startRun(8'd8, KEY256, PT, CT256);
    waitResult("nk8");
    startRun(8'd5, {128'h0, KEY128}, PT, CT128);
    waitResult("nk5");

    startRun(8'd4, {128'h0, 128'h2b7e151628aed2a6abf7158809cf4f3c},
             128'h3243f6a8885a308d313198a2e0370734, 128'h3925841d02dc09fbdc118597196a0b32);
    waitResult("fipsKey");
    checkVal("word4", 512'(key_schedule[1791 -: 32]), 512'h a0fafe17);
    checkVal("word43", 512'(key_schedule[543 -: 32]), 512'h b6630ca6);
    checkVal("words44to59", key_schedule[511:0], '0);

    @(negedge clk);
    reset      = 1'b1;
    nk         = 8'd8;
    cipher_key = KEY256;
    plain_text = PT;
    @(negedge clk);
    reset = 1'b0;
    repeat (60) @(negedge clk);
    checkVal("abortMidRun", 512'({key_expansion_done, cipher_done}), 512'b10);
    reset = 1'b1;
    @(negedge clk);
    checkVal("abortCleared", {cipher_text, key_expansion_done, cipher_done, |key_schedule}, '0);
    startRun(8'd4, {128'h0, KEY128}, PT, CT128);
    waitResult("afterAbort");

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
